pwm_breath_ctrl: RTL and testbench
==================================

Name: pwm_breath_ctrl

Overview:
- Sequencer that drives the Duty and Count_P inputs of the team's PWM generator to produce a repeating "breathing" profile: ramp up, hold high, ramp down, hold low, repeat.
- Runs a period counter in lock-step with the generator, so Duty changes only at PWM period boundaries and never glitches mid-period.
- Sits between the control/UI logic (Start/Stop/Step) and the PWM generator instance.

Parameters:
- PERIOD, 24'd50000: PWM period in CLK cycles (1 kHz at 50 MHz); driven on Count_P. Legal range ≥ 2.
- STEP_PERIODS, 16'd10: PWM periods between successive duty steps. Legal range ≥ 1.
- HOLD_PERIODS, 16'd50: PWM periods spent in each hold state. Legal range ≥ 1.
- DUTY_MAX, 8'd100: duty ceiling in percent. Legal range 1..100.

Ports:
- CLK, input, 1: system clock.
- RST, input, 1: synchronous reset, active-high.
- Start, input, 1: single-cycle request to begin breathing; honoured only in IDLE.
- Stop, input, 1: request to end breathing; honoured in any non-IDLE state.
- Step, input, 8: duty increment per step, in percent; sampled on accepted Start.
- Duty, output, 8: duty command to the PWM generator, in percent.
- Count_P, output, 24: period command to the PWM generator; constant PERIOD.
- Period_Tick, output, 1: high for one cycle on the last cycle of each PWM period.
- Busy, output, 1: high in every state except IDLE.
- State, output, 3: current state for debug. Encoding: IDLE=0, RAMP_UP=1, HOLD_HI=2, RAMP_DN=3, HOLD_LO=4.

Behaviour:
- Reset (RST=1 at a CLK edge):
  - Cnt=0, step/hold counter=0, Duty=0, State=IDLE, Busy=0, Period_Tick=0, latched step=1.
  - Count_P=PERIOD at all times, including during reset.
- Period counter:
  - Free-runs 0..PERIOD-1 and wraps to 0. It runs in every state, including IDLE.
  - Period_Tick = (Cnt == PERIOD-1), combinational from Cnt.
  - Releasing reset together with the generator's reset keeps both counters in phase.
- All state, Duty, and step/hold counter updates occur only on cycles with Period_Tick=1. Exception: Start acceptance, described below. Updated Duty is registered, so it is visible from Cnt=0 of the next period.
- IDLE:
  - Duty held at 0.
  - Start=1 on any cycle: latch step = (Step==0 ? 1 : Step), clear the step counter, go to RAMP_UP on the next cycle.
- RAMP_UP:
  - On each tick the step counter increments.
  - When it reaches STEP_PERIODS-1 on a tick: clear it and set Duty = min(Duty+step, DUTY_MAX). Compute in 9 bits so there is no 8-bit wrap.
  - If the new Duty equals DUTY_MAX: go to HOLD_HI with the counter cleared.
- HOLD_HI: after HOLD_PERIODS ticks, go to RAMP_DN with the counter cleared.
- RAMP_DN:
  - Mirror of RAMP_UP: Duty = (Duty > step) ? Duty-step : 0.
  - When the new Duty equals 0: go to HOLD_LO.
- HOLD_LO: after HOLD_PERIODS ticks, go to RAMP_UP (the loop repeats indefinitely).
- Stop:
  - Latched into a pending flag on any cycle while Busy.
  - At the next tick: State=IDLE, Duty=0, counters cleared, pending flag cleared.
  - Stop has priority over the step/hold update on that tick.
  - Stop while IDLE is ignored.
- Start while Busy is ignored; Step is not re-sampled.
- Start and Stop asserted in the same cycle:
  - In IDLE, Start wins and Stop is ignored.
  - When Busy, Stop wins.
- Large steps: step ≥ DUTY_MAX jumps straight to DUTY_MAX, and straight back to 0 in RAMP_DN.
- Reset mid-sequence: immediate return to the reset values above; the in-progress profile is abandoned.

Test Plan:
Common parameters for all scenarios: PERIOD=10, STEP_PERIODS=2, HOLD_PERIODS=3, DUTY_MAX=100.
1. Reset then idle:
   - Stimulus: RST high for 3 cycles, then low for 40 cycles, no Start.
   - Required: Duty=0, Busy=0, State=0, Count_P=10, Period_Tick pulses every 10 cycles at Cnt=9.
2. Full cycle:
   - Stimulus: Step=50, Start pulse.
   - Required Duty sequence, one change per 2 periods, each change first visible at a period start: 0→50→100.
   - Then HOLD_HI for 3 periods, then 100→50→0, then HOLD_LO for 3 periods, then RAMP_UP again.
3. Saturation:
   - Stimulus: Step=30.
   - Required: Duty 30, 60, 90, 100 (clamped), then HOLD_HI; ramp down 70, 40, 10, 0 (floored).
4. Step=0 and oversize step:
   - Step=0: Duty increments by 1 per step.
   - Step=200: Duty goes 0→100 in one step, then →0 in one step.
5. Stop mid-ramp:
   - Stimulus: Stop pulse at Cnt=3 while in RAMP_UP at Duty=50.
   - Required: Duty remains 50 until the tick at Cnt=9; then Duty=0, State=IDLE, Busy=0.
   - Start with Stop in the same cycle while Busy: Stop wins.
6. Reset mid-hold:
   - Stimulus: RST pulse during HOLD_HI.
   - Required: Duty=0 and State=IDLE on the next cycle, Cnt restarts at 0.
   - A later Start resumes a normal profile from Duty=0.

Source files
------------

// File: rtl/pwm_breath_ctrl.sv
// Breathing-profile sequencer for the PWM generator: ramps Duty up, holds, ramps down, holds, repeats.
// Duty changes only on the last cycle of a PWM period, so the generator never sees a mid-period change.
module pwm_breath_ctrl #(
    parameter logic [23:0] PERIOD       = 24'd50000,
    parameter logic [15:0] STEP_PERIODS = 16'd10,
    parameter logic [15:0] HOLD_PERIODS = 16'd50,
    parameter logic [7:0]  DUTY_MAX     = 8'd100
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Start,
    input  logic        Stop,
    input  logic [7:0]  Step,
    output logic [7:0]  Duty,
    output logic [23:0] Count_P,
    output logic        Period_Tick,
    output logic        Busy,
    output logic [2:0]  State
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RAMP_UP = 3'd1,
        HOLD_HI = 3'd2,
        RAMP_DN = 3'd3,
        HOLD_LO = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [23:0] cnt;
    logic [15:0] seq_cnt, seq_cnt_nxt;
    logic [7:0]  duty, duty_nxt;
    logic [7:0]  step_q, step_nxt;
    logic        stop_pend, stop_pend_nxt;

    logic [8:0]  duty_sum;
    logic [7:0]  duty_up;
    logic [7:0]  duty_dn;
    logic        stop_now;

    assign Count_P     = PERIOD;
    assign Period_Tick = (cnt == PERIOD - 24'd1);
    assign Busy        = (state != IDLE);
    assign State       = state;
    assign Duty        = duty;

    // Nine-bit sum so a large step clamps at DUTY_MAX instead of wrapping.
    assign duty_sum = {1'b0, duty} + {1'b0, step_q};
    assign duty_up  = (duty_sum >= {1'b0, DUTY_MAX}) ? DUTY_MAX : duty_sum[7:0];
    assign duty_dn  = (duty > step_q) ? (duty - step_q) : 8'd0;
    assign stop_now = Busy && (stop_pend || Stop);

    // Period counter runs in every state so it stays in phase with the generator.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= 24'd0;
        end else if (Period_Tick) begin
            cnt <= 24'd0;
        end else begin
            cnt <= cnt + 24'd1;
        end
    end

    // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            seq_cnt   <= 16'd0;
            duty      <= 8'd0;
            step_q    <= 8'd1;
            stop_pend <= 1'b0;
        end else begin
            state     <= state_nxt;
            seq_cnt   <= seq_cnt_nxt;
            duty      <= duty_nxt;
            step_q    <= step_nxt;
            stop_pend <= stop_pend_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt     = state;
        seq_cnt_nxt   = seq_cnt;
        duty_nxt      = duty;
        step_nxt      = step_q;
        stop_pend_nxt = stop_pend | (Busy & Stop);

        case (state)
            IDLE: begin
                duty_nxt      = 8'd0;
                stop_pend_nxt = 1'b0;
                if (Start) begin
                    step_nxt    = (Step == 8'd0) ? 8'd1 : Step;
                    seq_cnt_nxt = 16'd0;
                    state_nxt   = RAMP_UP;
                end
            end
            default: begin
                if (Period_Tick) begin
                    if (stop_now) begin
                        state_nxt     = IDLE;
                        duty_nxt      = 8'd0;
                        seq_cnt_nxt   = 16'd0;
                        stop_pend_nxt = 1'b0;
                    end else begin
                        case (state)
                            RAMP_UP: begin
                                if (seq_cnt == STEP_PERIODS - 16'd1) begin
                                    seq_cnt_nxt = 16'd0;
                                    duty_nxt    = duty_up;
                                    if (duty_up == DUTY_MAX) state_nxt = HOLD_HI;
                                end else begin
                                    seq_cnt_nxt = seq_cnt + 16'd1;
                                end
                            end
                            HOLD_HI: begin
                                if (seq_cnt == HOLD_PERIODS - 16'd1) begin
                                    seq_cnt_nxt = 16'd0;
                                    state_nxt   = RAMP_DN;
                                end else begin
                                    seq_cnt_nxt = seq_cnt + 16'd1;
                                end
                            end
                            RAMP_DN: begin
                                if (seq_cnt == STEP_PERIODS - 16'd1) begin
                                    seq_cnt_nxt = 16'd0;
                                    duty_nxt    = duty_dn;
                                    if (duty_dn == 8'd0) state_nxt = HOLD_LO;
                                end else begin
                                    seq_cnt_nxt = seq_cnt + 16'd1;
                                end
                            end
                            HOLD_LO: begin
                                if (seq_cnt == HOLD_PERIODS - 16'd1) begin
                                    seq_cnt_nxt = 16'd0;
                                    state_nxt   = RAMP_UP;
                                end else begin
                                    seq_cnt_nxt = seq_cnt + 16'd1;
                                end
                            end
                            default: state_nxt = IDLE;
                        endcase
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_pwm_breath_ctrl.sv
// Self-checking bench for pwm_breath_ctrl: per-period expected Duty/State pushed to a scoreboard queue
// and popped at the start of each PWM period.
module tb_pwm_breath_ctrl;

    localparam logic [23:0] PERIOD       = 24'd10;
    localparam logic [15:0] STEP_PERIODS = 16'd2;
    localparam logic [15:0] HOLD_PERIODS = 16'd3;
    localparam logic [7:0]  DUTY_MAX     = 8'd100;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RU   = 3'd1;
    localparam logic [2:0] S_HH   = 3'd2;
    localparam logic [2:0] S_RD   = 3'd3;
    localparam logic [2:0] S_HL   = 3'd4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Start;
    logic        Stop;
    logic [7:0]  Step;
    logic [7:0]  Duty;
    logic [23:0] Count_P;
    logic        Period_Tick;
    logic        Busy;
    logic [2:0]  State;

    pwm_breath_ctrl #(
        .PERIOD      (PERIOD),
        .STEP_PERIODS(STEP_PERIODS),
        .HOLD_PERIODS(HOLD_PERIODS),
        .DUTY_MAX    (DUTY_MAX)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Start      (Start),
        .Stop       (Stop),
        .Step       (Step),
        .Duty       (Duty),
        .Count_P    (Count_P),
        .Period_Tick(Period_Tick),
        .Busy       (Busy),
        .State      (State)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [7:0] duty;
        logic [2:0] state;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] cur_duty = 8'd0;

    task automatic push_seg(input logic [7:0] d, input logic [2:0] s, input int n);
        exp_t e;
        e.duty  = d;
        e.state = s;
        repeat (n) sb.push_back(e);
    endtask

    task automatic expect_idle(input string tag);
        n_checks++;
        if (Duty !== 8'd0) begin n_fail++; $display("FAIL %s duty: got %0d want 0", tag, Duty); end
        n_checks++;
        if (State !== S_IDLE) begin n_fail++; $display("FAIL %s state: got %0d want 0", tag, State); end
        n_checks++;
        if (Busy !== 1'b0) begin n_fail++; $display("FAIL %s busy: got %b want 0", tag, Busy); end
    endtask

    // Waits for Period_Tick, checking Duty stays at the current period's value meanwhile.
    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * int'(PERIOD); i++) begin
            @(negedge CLK);
            n_checks++;
            if (Duty !== cur_duty) begin
                n_fail++;
                $display("FAIL duty_stable: got %0d want %0d at %0t", Duty, cur_duty, $time);
            end
            if (Period_Tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL tick_timeout: no Period_Tick within %0d cycles at %0t", 2 * int'(PERIOD), $time);
        end
    endtask

    // Pops one expectation per PWM period and compares at Cnt=0 of that period.
    task automatic check_periods(input string tag);
        while (sb.size() > 0) begin
            exp_t e;
            bit   ok;
            wait_tick(ok);
            @(negedge CLK);
            e = sb.pop_front();
            n_checks++;
            if (Duty !== e.duty) begin
                n_fail++; $display("FAIL %s duty: got %0d want %0d at %0t", tag, Duty, e.duty, $time);
            end
            n_checks++;
            if (State !== e.state) begin
                n_fail++; $display("FAIL %s state: got %0d want %0d at %0t", tag, State, e.state, $time);
            end
            n_checks++;
            if (Busy !== (e.state != S_IDLE)) begin
                n_fail++; $display("FAIL %s busy: got %b want %b at %0t", tag, Busy, e.state != S_IDLE, $time);
            end
            cur_duty = e.duty;
        end
    endtask

    // Called at Cnt=0 in IDLE; leaves the bench at Cnt=1 in RAMP_UP.
    task automatic start_profile(input logic [7:0] s, input logic with_stop);
        Step  = s;
        Start = 1'b1;
        Stop  = with_stop;
        @(negedge CLK);
        Start = 1'b0;
        Stop  = 1'b0;
        cur_duty = 8'd0;
        n_checks++;
        if (State !== S_RU || Busy !== 1'b1) begin
            n_fail++; $display("FAIL start_accept: state %0d busy %b want 1/1", State, Busy);
        end
    endtask

    // Called at Cnt=0 while busy; ends at Cnt=0 of the first IDLE period.
    task automatic stop_to_idle(input string tag, input logic with_start);
        bit ok;
        Stop  = 1'b1;
        Start = with_start;
        Step  = 8'd200;
        @(negedge CLK);
        Stop  = 1'b0;
        Start = 1'b0;
        wait_tick(ok);
        @(negedge CLK);
        expect_idle(tag);
        cur_duty = 8'd0;
    endtask

    task automatic test_reset;
        RST = 1'b1; Start = 1'b0; Stop = 1'b0; Step = 8'd0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        n_checks++;
        if (Count_P !== 24'd10) begin n_fail++; $display("FAIL reset_count_p: got %0d want 10", Count_P); end
        n_checks++;
        if (Period_Tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b want 0", Period_Tick); end
        expect_idle("reset");
        RST = 1'b0;
        for (int k = 0; k < 40; k++) begin
            n_checks++;
            if (Period_Tick !== (k % 10 == 9)) begin
                n_fail++; $display("FAIL idle_tick k=%0d: got %b want %b", k, Period_Tick, k % 10 == 9);
            end
            n_checks++;
            if (Count_P !== 24'd10) begin n_fail++; $display("FAIL idle_count_p: got %0d want 10", Count_P); end
            expect_idle("idle");
            @(negedge CLK);
        end
    endtask

    task automatic test_full_cycle;
        start_profile(8'd50, 1'b0);
        push_seg(8'd0,   S_RU, 1);
        push_seg(8'd50,  S_RU, 2);
        push_seg(8'd100, S_HH, 3);
        push_seg(8'd100, S_RD, 2);
        push_seg(8'd50,  S_RD, 2);
        push_seg(8'd0,   S_HL, 3);
        push_seg(8'd0,   S_RU, 2);
        push_seg(8'd50,  S_RU, 1);
        check_periods("full");
        stop_to_idle("full_stop", 1'b0);
    endtask

    task automatic test_saturation;
        start_profile(8'd30, 1'b0);
        push_seg(8'd0,   S_RU, 1);
        push_seg(8'd30,  S_RU, 2);
        push_seg(8'd60,  S_RU, 2);
        push_seg(8'd90,  S_RU, 2);
        push_seg(8'd100, S_HH, 3);
        push_seg(8'd100, S_RD, 2);
        push_seg(8'd70,  S_RD, 2);
        push_seg(8'd40,  S_RD, 2);
        push_seg(8'd10,  S_RD, 2);
        push_seg(8'd0,   S_HL, 3);
        push_seg(8'd0,   S_RU, 1);
        check_periods("sat");
        stop_to_idle("sat_stop", 1'b0);
    endtask

    task automatic test_step_edges;
        start_profile(8'd0, 1'b0);
        push_seg(8'd0, S_RU, 1);
        push_seg(8'd1, S_RU, 2);
        push_seg(8'd2, S_RU, 2);
        push_seg(8'd3, S_RU, 1);
        check_periods("step0");
        stop_to_idle("step0_stop", 1'b0);

        start_profile(8'd200, 1'b0);
        push_seg(8'd0,   S_RU, 1);
        push_seg(8'd100, S_HH, 3);
        push_seg(8'd100, S_RD, 2);
        push_seg(8'd0,   S_HL, 3);
        push_seg(8'd0,   S_RU, 1);
        check_periods("step200");
        stop_to_idle("step200_stop", 1'b0);
    endtask

    task automatic test_stop;
        bit ok;
        start_profile(8'd50, 1'b0);
        push_seg(8'd0,  S_RU, 1);
        push_seg(8'd50, S_RU, 1);
        check_periods("stop_pre");
        repeat (3) @(negedge CLK);
        Stop = 1'b1;
        @(negedge CLK);
        Stop = 1'b0;
        for (int c = 4; c <= 9; c++) begin
            n_checks++;
            if (Duty !== 8'd50 || Busy !== 1'b1 || State !== S_RU) begin
                n_fail++; $display("FAIL stop_pending c=%0d: duty %0d busy %b state %0d want 50/1/1", c, Duty, Busy, State);
            end
            n_checks++;
            if (Period_Tick !== (c == 9)) begin
                n_fail++; $display("FAIL stop_tick c=%0d: got %b want %b", c, Period_Tick, c == 9);
            end
            if (c < 9) @(negedge CLK);
        end
        @(negedge CLK);
        expect_idle("stop_mid_ramp");
        cur_duty = 8'd0;

        // Stop in IDLE must not leave a pending stop behind.
        Stop = 1'b1;
        @(negedge CLK);
        Stop = 1'b0;
        wait_tick(ok);
        @(negedge CLK);
        expect_idle("stop_in_idle");

        // Start with Stop in IDLE: Start wins. Start while busy: ignored, Step not re-sampled.
        start_profile(8'd50, 1'b1);
        push_seg(8'd0, S_RU, 1);
        check_periods("start_stop_idle");
        Step  = 8'd200;
        Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        push_seg(8'd50, S_RU, 2);
        check_periods("start_busy");
        stop_to_idle("start_stop_busy", 1'b1);
    endtask

    task automatic test_reset_mid_hold;
        start_profile(8'd50, 1'b0);
        push_seg(8'd0,   S_RU, 1);
        push_seg(8'd50,  S_RU, 2);
        push_seg(8'd100, S_HH, 1);
        check_periods("hold_pre");
        repeat (4) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        expect_idle("reset_mid_hold");
        cur_duty = 8'd0;
        n_checks++;
        if (Period_Tick !== 1'b0) begin n_fail++; $display("FAIL rst_tick k=0: got %b want 0", Period_Tick); end
        for (int k = 1; k <= 9; k++) begin
            @(negedge CLK);
            n_checks++;
            if (Period_Tick !== (k == 9)) begin
                n_fail++; $display("FAIL rst_tick k=%0d: got %b want %b", k, Period_Tick, k == 9);
            end
        end
        @(negedge CLK);
        start_profile(8'd50, 1'b0);
        push_seg(8'd0,   S_RU, 1);
        push_seg(8'd50,  S_RU, 2);
        push_seg(8'd100, S_HH, 1);
        check_periods("resume");
        stop_to_idle("resume_stop", 1'b0);
    endtask

    initial begin
        test_reset();
        test_full_cycle();
        test_saturation();
        test_step_edges();
        test_stop();
        test_reset_mid_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
